// File: rtl/led_scan_driver.sv
// led_scan_driver: fetches one row of the 8x8x4 LED frame RAM into a
// line buffer, then scans it onto the matrix with 16-level column PWM.
module led_scan_driver #(
  parameter int SLOT_CYCLES  = 64,
  parameter int BLANK_CYCLES = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       ram_we,
  input  logic [3:0] led_data,
  output logic [7:0] addr_row,
  output logic [7:0] addr_col,
  output logic       fetch_active,
  output logic [7:0] row_out,
  output logic [7:0] col_out,
  output logic       frame_done
);

  localparam int MAXC = (SLOT_CYCLES > BLANK_CYCLES) ?
                        SLOT_CYCLES : BLANK_CYCLES;
  localparam int CW = (MAXC > 1) ? $clog2(MAXC) : 1;
  localparam logic [CW-1:0] SLOT_T  = CW'(SLOT_CYCLES - 1);
  localparam logic [CW-1:0] BLANK_T = CW'(BLANK_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE, FETCH_A, FETCH_B, SHOW, BLANK
  } state_e;

  state_e          state_q, state_d;
  logic [2:0]      row_q, row_d;
  logic [2:0]      col_q, col_d;
  logic [3:0]      pwm_q, pwm_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [7:0][3:0] buf_q, buf_d;

  logic [7:0] addr_row_q, addr_row_d;
  logic [7:0] addr_col_q, addr_col_d;
  logic       fetch_q, fetch_d;
  logic [7:0] row_out_q, row_out_d;
  logic [7:0] col_out_q, col_out_d;
  logic       done_q, done_d;
  logic       fetch_sel, show_sel;

  // Next state, then outputs decoded from the next state so that
  // every output register lines up with the state register.
  always_comb begin
    state_d    = state_q;
    row_d      = row_q;
    col_d      = col_q;
    pwm_d      = pwm_q;
    cnt_d      = cnt_q;
    buf_d      = buf_q;
    done_d     = 1'b0;
    addr_row_d = '0;
    addr_col_d = '0;
    fetch_d    = 1'b0;
    row_out_d  = '0;
    col_out_d  = '0;

    if (!en) begin
      state_d = IDLE;
      row_d   = '0;
      col_d   = '0;
      pwm_d   = '0;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          state_d = FETCH_A;
          row_d   = '0;
          col_d   = '0;
        end
        FETCH_A: begin
          // a write owns the RAM this cycle, so the read is retried
          if (!ram_we) state_d = FETCH_B;
        end
        FETCH_B: begin
          buf_d[col_q] = led_data;
          if (col_q != 3'd7) begin
            col_d   = col_q + 3'd1;
            state_d = FETCH_A;
          end else begin
            col_d   = '0;
            pwm_d   = '0;
            cnt_d   = '0;
            state_d = SHOW;
          end
        end
        SHOW: begin
          if (cnt_q == SLOT_T) begin
            cnt_d = '0;
            pwm_d = pwm_q + 4'd1;
            if (pwm_q == 4'd15) state_d = BLANK;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        BLANK: begin
          if (cnt_q == BLANK_T) begin
            cnt_d   = '0;
            row_d   = row_q + 3'd1;
            state_d = FETCH_A;
            done_d  = (row_q == 3'd7);
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end

    fetch_sel = (state_d == FETCH_A) || (state_d == FETCH_B);
    show_sel  = (state_d == SHOW);
    unique case (1'b1)
      fetch_sel: begin
        addr_row_d = 8'b1 << row_d;
        addr_col_d = 8'b1 << col_d;
        fetch_d    = 1'b1;
      end
      show_sel: begin
        row_out_d = 8'b1 << row_d;
        for (int j = 0; j < 8; j++)
          col_out_d[j] = (pwm_d < buf_d[j]);
      end
      default: ;
    endcase
  end

  // State, counters, line buffer and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      row_q      <= '0;
      col_q      <= '0;
      pwm_q      <= '0;
      cnt_q      <= '0;
      buf_q      <= '0;
      addr_row_q <= '0;
      addr_col_q <= '0;
      fetch_q    <= 1'b0;
      row_out_q  <= '0;
      col_out_q  <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      row_q      <= row_d;
      col_q      <= col_d;
      pwm_q      <= pwm_d;
      cnt_q      <= cnt_d;
      buf_q      <= buf_d;
      addr_row_q <= addr_row_d;
      addr_col_q <= addr_col_d;
      fetch_q    <= fetch_d;
      row_out_q  <= row_out_d;
      col_out_q  <= col_out_d;
      done_q     <= done_d;
    end
  end

  assign addr_row     = addr_row_q;
  assign addr_col     = addr_col_q;
  assign fetch_active = fetch_q;
  assign row_out      = row_out_q;
  assign col_out      = col_out_q;
  assign frame_done   = done_q;

endmodule

// File: tb/tb_led_scan_driver.sv
// tb_led_scan_driver: random frame contents, RAM model, row-level
// reference expectations queued and checked by a negedge monitor.
module tb_led_scan_driver;

  localparam int SLOT  = 4;
  localparam int BLANK = 2;
  localparam int LIM   = 5000;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic       ram_we;
  logic [3:0] led_data;
  logic [7:0] addr_row;
  logic [7:0] addr_col;
  logic       fetch_active;
  logic [7:0] row_out;
  logic [7:0] col_out;
  logic       frame_done;

  led_scan_driver #(
    .SLOT_CYCLES (SLOT),
    .BLANK_CYCLES(BLANK)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .en          (en),
    .ram_we      (ram_we),
    .led_data    (led_data),
    .addr_row    (addr_row),
    .addr_col    (addr_col),
    .fetch_active(fetch_active),
    .row_out     (row_out),
    .col_out     (col_out),
    .frame_done  (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // frame RAM: writer wins, reads registered one cycle
  logic [3:0] mem [8][8];
  logic [2:0] wr_r;
  logic [2:0] wr_c;
  logic [3:0] wr_d;

  function automatic int oh2i(input logic [7:0] v);
    int k;
    k = 0;
    for (int i = 0; i < 8; i++) if (v[i]) k = i;
    return k;
  endfunction

  always @(posedge clk) begin
    if (ram_we) mem[wr_r][wr_c] <= wr_d;
    else if (fetch_active)
      led_data <= mem[oh2i(addr_row)][oh2i(addr_col)];
  end

  typedef struct packed {
    int              r;
    logic [7:0][3:0] lv;
    int              flen;
    bit              full;
  } item_t;

  item_t sb[$];
  int    fd_t[$];
  int    total = 0;
  int    bad   = 0;
  int    n_pop = 0;
  int    cyc   = 0;
  int    excl_bad = 0;
  int    fd_wide  = 0;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic int outs_zero();
    return int'({addr_row, addr_col, row_out, col_out,
                 fetch_active, frame_done} == '0);
  endfunction

  // monitor state
  bit         fd_prev = 0;
  bit         f_in = 0, f_bad = 0, l_bad = 0;
  int         f_len = 0, f_c = 0, l_len = 0;
  logic [7:0] f_row = '0, l_row = '0;
  bit         s_in = 0;
  int         s_len = 0, s_mis = 0;
  logic [7:0] s_row = '0;
  item_t      cur;

  always @(negedge clk) begin
    cyc++;
    if (fetch_active && (row_out != 0 || col_out != 0)) excl_bad++;
    if (!fetch_active && (addr_row != 0 || addr_col != 0)) excl_bad++;
    if (row_out == 0 && col_out != 0) excl_bad++;

    if (frame_done) begin
      if (fd_prev) fd_wide++;
      fd_t.push_back(cyc);
    end
    fd_prev = frame_done;

    if (fetch_active) begin
      if (!f_in) begin
        f_in = 1; f_len = 0; f_c = 0; f_bad = 0; f_row = addr_row;
      end
      f_len++;
      if (addr_row != f_row) f_bad = 1;
      if (addr_col == (8'b1 << f_c)) begin
      end else if (f_c < 7 && addr_col == (8'b1 << (f_c + 1))) begin
        f_c++;
      end else begin
        f_bad = 1;
      end
    end else if (f_in) begin
      f_in = 0; l_len = f_len; l_row = f_row;
      l_bad = f_bad || (f_c != 7);
    end

    if (row_out != 0) begin
      if (!s_in) begin
        s_in = 1; s_len = 0; s_mis = 0; s_row = row_out;
        if (sb.size() > 0) cur = sb[0];
        else cur = '0;
      end
      if (row_out != s_row) s_mis++;
      for (int j = 0; j < 8; j++)
        if (col_out[j] != (s_len < int'(cur.lv[j]) * SLOT)) s_mis++;
      s_len++;
    end else if (s_in) begin
      s_in = 0;
      if (sb.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_row: got row_out %h expected none",
                 s_row);
      end else begin
        item_t it;
        it = sb.pop_front();
        chk("row_sel", int'(s_row), int'(8'b1 << it.r));
        chk("fetch_row", int'(l_row), int'(8'b1 << it.r));
        chk("fetch_len", l_len, it.flen);
        chk("fetch_order", int'(l_bad), 0);
        chk("pwm_pattern", s_mis, 0);
        if (it.full) chk("show_len", s_len, 16 * SLOT);
        n_pop++;
      end
    end
  end

  logic [3:0] ref0 [8][8];
  logic [3:0] ref1 [8][8];
  logic [3:0] newv;
  int         n;
  int         zbad;

  task automatic push_row(input int k, input int flen, input bit full);
    item_t it;
    it.r = k % 8;
    for (int c = 0; c < 8; c++)
      it.lv[c] = (k >= 2) ? ref1[it.r][c] : ref0[it.r][c];
    it.flen = flen;
    it.full = full;
    sb.push_back(it);
  endtask

  task automatic timeout(input string nm);
    total++; bad++;
    $display("FAIL %s: got timeout expected event", nm);
  endtask

  initial begin
    rst_n = 1'b1; en = 1'b0; ram_we = 1'b0;
    wr_r = '0; wr_c = '0; wr_d = '0;
    #1 rst_n = 1'b0;
    @(negedge clk);
    chk("reset_outputs", outs_zero(), 1);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++)
        ref0[r][c] = 4'($urandom_range(0, 15));
    for (int c = 0; c < 8; c++) ref0[0][c] = 4'(c);
    ref0[3][0] = 4'hF; ref0[3][1] = 4'h0; ref0[3][2] = 4'h8;
    newv = ref0[2][5] ^ 4'h9;
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++) ref1[r][c] = ref0[r][c];
    ref1[2][5] = newv;

    zbad = 0;
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++) begin
        wr_r = 3'(r); wr_c = 3'(c); wr_d = ref0[r][c]; ram_we = 1'b1;
        @(negedge clk);
        if (outs_zero() == 0) zbad++;
      end
    ram_we = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (outs_zero() == 0) zbad++;
    end
    chk("idle_en_low", zbad, 0);

    for (int k = 0; k < 20; k++) push_row(k, (k == 2) ? 19 : 16, 1'b1);
    push_row(20, 16, 1'b0);
    en = 1'b1;

    n = 0;
    while (!(fetch_active && addr_row == 8'h04 && addr_col == 8'h20)
           && n < LIM) begin
      @(negedge clk); n++;
    end
    if (n >= LIM) timeout("stall_point");
    wr_r = 3'd2; wr_c = 3'd5; wr_d = newv; ram_we = 1'b1;
    repeat (3) @(negedge clk);
    ram_we = 1'b0;

    n = 0;
    while (n_pop < 17 && n < LIM) begin @(negedge clk); n++; end
    if (n >= LIM) timeout("two_frames");
    chk("fd_count", fd_t.size(), 2);
    if (fd_t.size() >= 2)
      chk("fd_spacing", fd_t[1] - fd_t[0], 8 * (16 + 16 * SLOT + BLANK));
    chk("fd_width", fd_wide, 0);

    n = 0;
    while (!(n_pop >= 20 && row_out == 8'h10) && n < LIM) begin
      @(negedge clk); n++;
    end
    if (n >= LIM) timeout("row4_show");
    repeat (20) @(negedge clk);
    en = 1'b0;
    @(negedge clk);
    chk("idle_after_drop", outs_zero(), 1);
    zbad = 0;
    repeat (10) begin
      @(negedge clk);
      if (outs_zero() == 0) zbad++;
    end
    chk("idle_hold", zbad, 0);
    chk("no_fd_on_drop", fd_t.size(), 2);

    push_row(8, 16, 1'b0);
    en = 1'b1;
    n = 0;
    while (!fetch_active && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) timeout("restart");
    chk("restart_row", int'(addr_row), 8'h01);
    chk("restart_col", int'(addr_col), 8'h01);
    n = 0;
    while (row_out == 0 && n < 100) begin @(negedge clk); n++; end
    if (n >= 100) timeout("restart_show");
    repeat (10) @(negedge clk);
    #2 rst_n = 1'b0;
    en = 1'b0;
    #1 chk("async_reset", outs_zero(), 1);
    @(negedge clk);
    rst_n = 1'b1;
    zbad = 0;
    repeat (10) begin
      @(negedge clk);
      if (outs_zero() == 0) zbad++;
    end
    chk("post_reset_idle", zbad, 0);
    chk("sb_empty", sb.size(), 0);
    chk("exclusive", excl_bad, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/led_scan_driver.md
Name: led_scan_driver

Overview:
- Downstream consumer of the 8x8x4-bit LED frame RAM.
- Walks the RAM one row at a time using one-hot row/column addresses and captures the row's eight 4-bit intensities into a line buffer.
- Drives the physical matrix row-by-row: one-hot row select plus per-column PWM (16 levels), with a blanking gap between rows to suppress ghosting.
- Sits between the frame RAM read port and the matrix pins; the external address mux gives a RAM writer priority whenever `fetch_active` is low or `ram_we` is high.

Parameters:
- SLOT_CYCLES, 64: clk cycles per PWM slot. Legal range is ≥1. One row shows for 16 slots.
- BLANK_CYCLES, 8: clk cycles with all outputs off after each row. Legal range is ≥1.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous reset, active low.
- en  input  1  scan enable.
- ram_we  input  1  RAM write-enable as seen by the RAM. A high value in a read cycle invalidates that read.
- led_data  input  4  RAM read data. Registered in the RAM, valid 1 cycle after the address.
- addr_row  output  8  one-hot RAM row address.
- addr_col  output  8  one-hot RAM column address.
- fetch_active  output  1  high while the driver owns the RAM address bus.
- row_out  output  8  one-hot matrix row select, active high.
- col_out  output  8  matrix column drive, active high.
- frame_done  output  1  one-cycle pulse at the end of row 7's blank.

Behaviour:
- All outputs are registered.
- Reset (async, any state) forces:
  - state IDLE;
  - row index 0, column index 0, pwm_cnt 0, slot counter 0;
  - line buffer all 0;
  - every output 0.
- States: IDLE, FETCH_A, FETCH_B, SHOW, BLANK.
- IDLE:
  - All outputs 0.
  - en=1 → FETCH_A with row=0, col=0.
- FETCH_A:
  - addr_row=onehot(row), addr_col=onehot(col), fetch_active=1; row_out=0, col_out=0.
  - RAM latches led_data at the end of this cycle.
  - ram_we=1 during FETCH_A → stay in FETCH_A (retry same column), no capture.
  - Otherwise → FETCH_B.
- FETCH_B:
  - Address held.
  - At the end of the cycle, buf[col] <= led_data.
  - col<7 → col++ and FETCH_A.
  - col=7 → col=0, pwm_cnt=0, slot counter=0, SHOW.
  - ram_we during FETCH_B is ignored (data already latched).
- Fetch cost is 16 cycles per row with no write stalls; each stalled cycle adds 1.
- SHOW:
  - addr_row=0, addr_col=0, fetch_active=0.
  - row_out=onehot(row).
  - col_out[j] = (pwm_cnt < buf[j]), compared as unsigned 4-bit: level 0 is always off; level 15 is on 15/16 of the row time.
  - Slot counter counts 0..SLOT_CYCLES-1. At terminal count it resets and pwm_cnt++.
  - When pwm_cnt=15 and the slot counter is at terminal → BLANK.
  - SHOW length is exactly 16*SLOT_CYCLES cycles.
- BLANK:
  - row_out=0, col_out=0 for BLANK_CYCLES cycles.
  - Then row=(row+1) mod 8 (7 wraps to 0) → FETCH_A.
  - On leaving BLANK with row=7, frame_done=1 for exactly that one cycle.
- en=0 in any non-IDLE state:
  - next edge → IDLE, all outputs 0, row reset to 0;
  - no frame_done;
  - the partial row is discarded.
- en must be re-asserted for a restart, which always begins at row 0.
- Frame period with no stalls is 8*(16 + 16*SLOT_CYCLES + BLANK_CYCLES) cycles.
- Row output and column output are never active in the same cycle as fetch_active.
- buf is only updated in FETCH_B, so RAM writes during SHOW/BLANK take effect on that row's next fetch.

Test Plan:
- Reset/idle: with rst_n low mid-SHOW (SLOT=4, BLANK=2) → all outputs 0 asynchronously; after release with en=0 → outputs stay 0.
- Fetch sequencing: preload RAM row 0 = {0,1,…,7}, assert en → addr_row=8'h01 and addr_col steps 8'h01..8'h80, each held 2 cycles. fetch_active is high for exactly 16 cycles, then row_out=8'h01.
- PWM duty (SLOT=4): row 3, col 0 = 4'hF, col 1 = 4'h0, col 2 = 4'h8 → over the 64-cycle SHOW, col_out[0] is high 60 cycles, col_out[1] 0 cycles, col_out[2] 32 cycles (the first 32).
- Write stall: hold ram_we=1 for 3 cycles while the driver sits in FETCH_A at col 5 → FETCH_A repeats 3 extra times, the fetch lasts 19 cycles, and buf[5] holds the RAM value after the write.
- Wrap/frame_done (SLOT=4, BLANK=2): run 2 frames → row_out sequence 01,02,…,80,01. frame_done pulses once per frame, spaced 8*(16+64+2)=656 cycles apart.
- Enable drop: deassert en mid-SHOW on row 4 → IDLE next cycle, all outputs 0, no frame_done. Re-asserting en restarts the fetch at addr_row=8'h01.
